mem_stk_responder: RTL

- Responder for the control path's load/store requests; sits between the control path and a single-port synchronous data RAM.
- Accepts one read and/or write request per transaction, to either the memory space or the stack space.
- Sequences the RAM access: read before write when both are requested, matching the control path's wait_read then wait_write ordering.
- Returns load data with a one-cycle resp_valid pulse.

---
 rtl/mem_stk_responder.sv | 94 +++++++++
 1 files changed

// File: rtl/mem_stk_responder.sv
// rtl/mem_stk_responder.sv - load/store responder between control path and single-port data RAM
// Optional stack bounds checking: define STK_BOUNDS_EN.
`timescale 1ns/1ps
module mem_stk_responder #(
    parameter int                 ADDR_W    = 12,
    parameter int                 DATA_W    = 16,
    parameter logic [ADDR_W-1:0]  STK_BASE  = 12'hF00,
    parameter int                 STK_DEPTH = 256
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_read,
    input  logic              req_write,
    input  logic              req_stk,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int STK_W = $clog2(STK_DEPTH);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, WR, RESP} state_t;

    state_t            state;
    logic              wr_q;
    logic              accept;
    logic [STK_W-1:0]  stk_off;
    logic [ADDR_W-1:0] phys_addr;
    logic              err_q;

    assign accept  = (state == IDLE) && (req_read || req_write);
    assign stk_off = STK_W'(req_addr);

    // Stack offsets wrap modulo the (power-of-two) depth; memory addresses drop upper bits.
    always_comb begin
        phys_addr = ADDR_W'(req_addr);
        if (req_stk)
            phys_addr = STK_BASE + ADDR_W'(stk_off);
    end

`ifdef STK_BOUNDS_EN
    logic oob;
    assign oob = req_stk && (32'(req_addr) >= 32'(STK_DEPTH));
`endif

    // Handshake and write strobe decode straight from state so reset kills them at once.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign ram_we     = (state == WR) && !err_q;
    assign resp_error = (state == RESP) && err_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            resp_rdata <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q      <= req_write;
                        ram_addr  <= phys_addr;
                        ram_wdata <= req_wdata;
`ifdef STK_BOUNDS_EN
                        err_q     <= oob;
`else
                        err_q     <= 1'b0;
`endif
                        state     <= req_read ? RD_ISSUE : WR;
                    end
                end
                RD_ISSUE: state <= RD_CAPT;
                RD_CAPT: begin
                    resp_rdata <= err_q ? '0 : ram_rdata;
                    state      <= wr_q ? WR : RESP;
                end
                WR:      state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
